lockable_reg_bank: RTL and testbench
====================================

Name: lockable_reg_bank

Overview:
- Parametrised successor to the single lock-protected data register: a bank of NUM_REGS registers of WIDTH bits, each with its own sticky lock bit.
- Locked registers become writable only through an authenticated, time-limited debug unlock session. A key-check FSM enforces lockout and a permanent fail state.
- scan_mode never bypasses locks. Entering scan zeroizes register contents.
- Sits beside the core register file as the protected configuration/secret store.

Parameters:
- NUM_REGS, 8: number of registers (2..32).
- WIDTH, 16: bits per register.
- DBG_KEY, 16'hA5C3: 16-bit debug unlock key.
- UNLOCK_CYCLES, 64: length of a debug session in cycles.
- LOCKOUT_CYCLES, 32: cycles during which dbg_req is ignored after a bad key.
- MAX_FAILS, 3: bad keys before permanent debug disable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  AW=$clog2(NUM_REGS)  write address.
- wr_data  in  WIDTH  write data.
- rd_addr  in  AW  read address.
- rd_data  out  WIDTH  combinational read data.
- lock_en  in  1  set the lock bit of lock_addr.
- lock_addr  in  AW  register to lock.
- lock_all  in  1  set every lock bit.
- scan_mode  in  1  scan/test mode.
- dbg_req  in  1  one-cycle unlock attempt.
- dbg_key  in  16  key presented with dbg_req.
- dbg_exit  in  1  end the debug session early.
- lock_status  out  NUM_REGS  per-register lock bits.
- dbg_unlocked  out  1  high while the FSM is in UNLOCKED.
- dbg_dead  out  1  high in state DEAD.
- wr_err  out  1  one-cycle pulse the cycle after a rejected write.

Behaviour:
- Reset values:
  - All registers 0; lock_status 0; FSM IDLE.
  - fail_cnt 0; timer 0; wr_err 0; dbg_unlocked 0; dbg_dead 0.
  - rd_data = reg[rd_addr] = 0.
  - Reset mid-session returns to IDLE immediately; DEAD is also cleared.
- Read:
  - rd_data = reg[rd_addr], zero latency.
  - rd_addr >= NUM_REGS returns 0.
- Write (priority: reset > scan zeroize > write):
  - Accepted when wr_en, wr_addr < NUM_REGS, and (lock bit == 0 or dbg_unlocked == 1).
  - Data is visible on rd_data the next cycle.
  - Otherwise the write is dropped and wr_err=1 in the next cycle.
  - scan_mode does not grant write access.
- Locks:
  - lock_en or lock_all set bits at the clock edge. Bits are sticky until reset; there is no clear path, debug included.
  - The write permission check uses the pre-edge lock bit. A write and a lock of the same register in the same cycle therefore complete the write and set the lock.
  - lock_addr >= NUM_REGS is ignored.
- Scan:
  - On a rising edge of scan_mode (registered 0->1), all data registers clear to 0 on that clock.
  - Any write in that cycle is discarded, with no wr_err.
  - Lock bits are retained.
  - An UNLOCKED session is forced to IDLE.
  - While scan_mode stays high, normal write rules apply.
- Debug FSM states are IDLE, UNLOCKED, LOCKOUT, DEAD. The timer decrements every cycle in UNLOCKED and LOCKOUT.
- IDLE transitions:
  - dbg_req with dbg_key==DBG_KEY: go to UNLOCKED, timer=UNLOCK_CYCLES-1, fail_cnt=0.
  - dbg_req with a bad key: fail_cnt+1. If the new count == MAX_FAILS, go to DEAD; else go to LOCKOUT with timer=LOCKOUT_CYCLES-1.
- UNLOCKED:
  - Exits to IDLE on any of: timer==0, dbg_exit, or a scan_mode rising edge.
  - dbg_req is ignored.
  - A write in the exit cycle is still evaluated as unlocked.
- LOCKOUT: dbg_req is ignored (no fail counted); go to IDLE when timer==0.
- DEAD: absorbing until reset.
- dbg_unlocked and dbg_dead are registered state decodes, not combinational from inputs.
- Session length is exactly UNLOCK_CYCLES cycles with dbg_unlocked=1, starting the cycle after the accepted dbg_req.

Test Plan:
- Basic write/read after reset: write 0x1234 to reg3 -> rd_data=0x1234 at rd_addr=3 next cycle; reg0..7 otherwise 0.
- Lock protection: lock_en reg3, then write 0xFFFF to reg3 -> reg3 stays 0x1234, wr_err pulses one cycle; the same write to reg4 succeeds with no wr_err.
- Debug unlock session: dbg_req key 0xA5C3 -> dbg_unlocked high for exactly 64 cycles, during which a write of 0xBEEF to locked reg3 succeeds. The same write on cycle 65 is rejected with wr_err.
- Bad keys and DEAD:
  - Key 0x0000 -> LOCKOUT; dbg_req with the correct key within 32 cycles is ignored.
  - After three bad keys -> dbg_dead=1, and a correct key never unlocks.
  - reset clears dbg_dead.
- Scan entry zeroize: regs loaded, reg3 locked, scan_mode 0->1 during UNLOCKED -> all regs read 0, lock_status[3] still 1, dbg_unlocked 0 next cycle. A write to reg3 under scan is rejected.
- Simultaneous write and lock of reg5 with data 0x0A0A -> reg5=0x0A0A, lock_status[5]=1; a following write is rejected. lock_all sets lock_status to 0xFF.

Source files
------------

// File: rtl/lockable_reg_bank.sv
// Bank of lockable configuration registers. Once a register's lock bit is set,
// the register can only be written during an authenticated, time-limited debug session.
module lockable_reg_bank #(
  parameter int          NUM_REGS       = 8,
  parameter int          WIDTH          = 16,
  parameter logic [15:0] DBG_KEY        = 16'hA5C3,
  parameter int          UNLOCK_CYCLES  = 64,
  parameter int          LOCKOUT_CYCLES = 32,
  parameter int          MAX_FAILS      = 3,
  localparam int         AW             = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  input  logic                lock_en,
  input  logic [AW-1:0]       lock_addr,
  input  logic                lock_all,
  input  logic                scan_mode,
  input  logic                dbg_req,
  input  logic [15:0]         dbg_key,
  input  logic                dbg_exit,
  output logic [NUM_REGS-1:0] lock_status,
  output logic                dbg_unlocked,
  output logic                dbg_dead,
  output logic                wr_err
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_UNLOCKED, ST_LOCKOUT, ST_DEAD} dbg_state_t;

  dbg_state_t        state_reg;
  logic [TW-1:0]     timer_reg;
  logic [FW-1:0]     fail_cnt_reg;
  logic              dbg_unlocked_reg;
  logic              dbg_dead_reg;
  logic              wr_err_reg;
  logic              scan_q_reg;

  logic [WIDTH-1:0]  mem_q [NUM_REGS];
  logic              scan_rise;
  logic              wr_addr_ok;
  logic              wr_ok;

  assign scan_rise  = scan_mode & ~scan_q_reg;
  assign wr_addr_ok = ({1'b0, wr_addr} < (AW + 1)'(NUM_REGS));
  // The permission check deliberately uses the pre-edge lock bit and session flag.
  assign wr_ok      = wr_en & wr_addr_ok & (~lock_status[wr_addr] | dbg_unlocked_reg);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [WIDTH-1:0] data_reg;
      logic             lock_bit_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg     <= '0;
          lock_bit_reg <= 1'b0;
        end else begin
          if (scan_rise)
            data_reg <= '0;
          else if (wr_ok && (wr_addr == AW'(gi)))
            data_reg <= wr_data;
          if (lock_all || (lock_en && (lock_addr == AW'(gi))))
            lock_bit_reg <= 1'b1;
        end
      end

      assign mem_q[gi]       = data_reg;
      assign lock_status[gi] = lock_bit_reg;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < (AW + 1)'(NUM_REGS))
      rd_data = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q_reg <= 1'b0;
      wr_err_reg <= 1'b0;
    end else begin
      scan_q_reg <= scan_mode;
      // A write swallowed by the scan zeroize is not an error.
      wr_err_reg <= wr_en & ~scan_rise & ~wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      timer_reg        <= '0;
      fail_cnt_reg     <= '0;
      dbg_unlocked_reg <= 1'b0;
      dbg_dead_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dbg_req) begin
            if (dbg_key == DBG_KEY) begin
              state_reg        <= ST_UNLOCKED;
              timer_reg        <= TW'(UNLOCK_CYCLES - 1);
              fail_cnt_reg     <= '0;
              dbg_unlocked_reg <= 1'b1;
            end else begin
              fail_cnt_reg <= fail_cnt_reg + FW'(1);
              if ((fail_cnt_reg + FW'(1)) == FW'(MAX_FAILS)) begin
                state_reg    <= ST_DEAD;
                dbg_dead_reg <= 1'b1;
              end else begin
                state_reg <= ST_LOCKOUT;
                timer_reg <= TW'(LOCKOUT_CYCLES - 1);
              end
            end
          end
        end
        ST_UNLOCKED: begin
          if ((timer_reg == '0) || dbg_exit || scan_rise) begin
            state_reg        <= ST_IDLE;
            timer_reg        <= '0;
            dbg_unlocked_reg <= 1'b0;
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        ST_LOCKOUT: begin
          if (timer_reg == '0)
            state_reg <= ST_IDLE;
          else
            timer_reg <= timer_reg - TW'(1);
        end
        default: begin
          state_reg    <= ST_DEAD;
          dbg_dead_reg <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_unlocked = dbg_unlocked_reg;
  assign dbg_dead     = dbg_dead_reg;
  assign wr_err       = wr_err_reg;

endmodule

// File: tb/tb_lockable_reg_bank.sv
// Directed bench for lockable_reg_bank: a cycle-level behavioural model is checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_lockable_reg_bank;
  localparam int NR = 8;
  localparam int W  = 16;
  localparam int AW = 3;
  localparam logic [15:0] KEY = 16'hA5C3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          lock_en;
  logic [AW-1:0] lock_addr;
  logic          lock_all;
  logic          scan_mode;
  logic          dbg_req;
  logic [15:0]   dbg_key;
  logic          dbg_exit;
  logic [NR-1:0] lock_status;
  logic          dbg_unlocked;
  logic          dbg_dead;
  logic          wr_err;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  lockable_reg_bank dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .lock_en(lock_en), .lock_addr(lock_addr),
    .lock_all(lock_all), .scan_mode(scan_mode), .dbg_req(dbg_req), .dbg_key(dbg_key),
    .dbg_exit(dbg_exit), .lock_status(lock_status), .dbg_unlocked(dbg_unlocked),
    .dbg_dead(dbg_dead), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Model: debug session described as remaining-cycle counts, not as FSM states.
  logic [W-1:0]  m_mem [NR];
  logic [NR-1:0] m_lock;
  int            m_unlock_left, m_lockout_left, m_fails;
  bit            m_dead, m_wr_err, m_prev_scan;

  always @(posedge clk) begin
    bit unl, idle, rise, ok;
    unl  = (m_unlock_left > 0);
    idle = !m_dead && (m_unlock_left == 0) && (m_lockout_left == 0);
    rise = scan_mode && !m_prev_scan;
    ok   = wr_en && (int'(wr_addr) < NR) && (!m_lock[wr_addr] || unl);
    if (reset) begin
      for (int i = 0; i < NR; i++) m_mem[i] = '0;
      m_lock = '0; m_unlock_left = 0; m_lockout_left = 0; m_fails = 0;
      m_dead = 0; m_wr_err = 0; m_prev_scan = 0;
    end else begin
      m_wr_err = wr_en && !rise && !ok;
      if (rise) for (int i = 0; i < NR; i++) m_mem[i] = '0;
      else if (ok) m_mem[wr_addr] = wr_data;
      if (lock_all) m_lock = '1;
      if (lock_en && int'(lock_addr) < NR) m_lock[lock_addr] = 1'b1;
      if (unl) begin
        if (dbg_exit || rise) m_unlock_left = 0;
        else m_unlock_left--;
      end
      if (m_lockout_left > 0) m_lockout_left--;
      if (idle && dbg_req) begin
        if (dbg_key == KEY) begin
          m_unlock_left = 64; m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == 3) m_dead = 1;
          else m_lockout_left = 32;
        end
      end
      m_prev_scan = scan_mode;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_rd_data", 32'(rd_data), 32'((int'(rd_addr) < NR) ? m_mem[rd_addr] : '0));
      chk("m_lock_status", 32'(lock_status), 32'(m_lock));
      chk("m_dbg_unlocked", 32'(dbg_unlocked), 32'(m_unlock_left > 0));
      chk("m_dbg_dead", 32'(dbg_dead), 32'(m_dead));
      chk("m_wr_err", 32'(wr_err), 32'(m_wr_err));
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic quiet();
    reset = 0; wr_en = 0; lock_en = 0; lock_all = 0; dbg_req = 0; dbg_exit = 0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    wr_en = 1; wr_addr = AW'(a); wr_data = d; rd_addr = AW'(a);
    cyc(); wr_en = 0;
  endtask

  task automatic req(input logic [15:0] k);
    dbg_req = 1; dbg_key = k; cyc(); dbg_req = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; cyc(); cyc(); reset = 0;
  endtask

  initial begin
    int n;
    quiet(); scan_mode = 0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    lock_addr = '0; dbg_key = '0;
    do_reset();
    chk_on = 1'b1;
    chk("reset_rd", 32'(rd_data), 32'h0);
    chk("reset_lock", 32'(lock_status), 32'h0);
    chk("reset_dbg", {dbg_unlocked, dbg_dead, wr_err}, 32'h0);
    $display("reset done");

    wr(3, 16'h1234);
    chk("basic_rd3", 32'(rd_data), 32'h1234);
    rd_addr = 3'd2; #1 chk("basic_rd2", 32'(rd_data), 32'h0);
    $display("write reg3 0x1234");

    lock_en = 1; lock_addr = 3'd3; cyc(); lock_en = 0;
    wr(3, 16'hFFFF);
    chk("lock_rd3", 32'(rd_data), 32'h1234);
    chk("lock_wr_err", 32'(wr_err), 32'h1);
    cyc();
    chk("lock_wr_err_pulse", 32'(wr_err), 32'h0);
    wr(4, 16'hFFFF);
    chk("unlocked_rd4", 32'(rd_data), 32'hFFFF);
    chk("unlocked_wr_err", 32'(wr_err), 32'h0);
    $display("lock reg3, write rejected; reg4 written");

    req(KEY);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (dbg_unlocked) n++;
      wr_en = (i == 0); wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr = 3'd3;
      cyc();
    end
    wr_en = 0;
    chk("session_len", 32'(n), 32'd64);
    chk("session_rd3", 32'(rd_data), 32'hBEEF);
    wr(3, 16'h5A5A);
    chk("post_session_err", 32'(wr_err), 32'h1);
    chk("post_session_rd3", 32'(rd_data), 32'hBEEF);
    $display("debug session %0d cycles", n);

    req(16'h0000);
    chk("bad_key_unl", 32'(dbg_unlocked), 32'h0);
    req(KEY);
    chk("lockout_ignore", 32'(dbg_unlocked), 32'h0);
    repeat (40) cyc();
    req(16'h1111);
    repeat (40) cyc();
    req(16'h2222);
    chk("dead_after_3", 32'(dbg_dead), 32'h1);
    req(KEY); cyc();
    chk("dead_no_unlock", 32'(dbg_unlocked), 32'h0);
    do_reset();
    chk("reset_clears_dead", 32'(dbg_dead), 32'h0);
    $display("bad keys, dead, reset");

    wr(3, 16'h1111);
    wr(0, 16'h2222);
    lock_en = 1; lock_addr = 3'd3; cyc(); lock_en = 0;
    req(KEY); repeat (3) cyc();
    scan_mode = 1; wr_en = 1; wr_addr = 3'd0; wr_data = 16'h7777; rd_addr = 3'd0;
    cyc(); wr_en = 0;
    chk("scan_zero_rd0", 32'(rd_data), 32'h0);
    chk("scan_no_err", 32'(wr_err), 32'h0);
    chk("scan_lock3", 32'(lock_status[3]), 32'h1);
    chk("scan_unl_off", 32'(dbg_unlocked), 32'h0);
    wr(3, 16'h3333);
    chk("scan_locked_err", 32'(wr_err), 32'h1);
    chk("scan_rd3", 32'(rd_data), 32'h0);
    wr(1, 16'h4444);
    chk("scan_normal_wr", 32'(rd_data), 32'h4444);
    scan_mode = 0; cyc();
    $display("scan zeroize");

    lock_en = 1; lock_addr = 3'd5; wr(5, 16'h0A0A); lock_en = 0;
    chk("wrlock_rd5", 32'(rd_data), 32'h0A0A);
    chk("wrlock_bit5", 32'(lock_status[5]), 32'h1);
    wr(5, 16'h1234);
    chk("wrlock_err", 32'(wr_err), 32'h1);
    chk("wrlock_keep", 32'(rd_data), 32'h0A0A);
    lock_all = 1; cyc(); lock_all = 0;
    chk("lock_all", 32'(lock_status), 32'hFF);
    $display("write+lock reg5, lock_all");

    req(KEY); repeat (5) cyc();
    dbg_exit = 1; cyc(); dbg_exit = 0;
    chk("dbg_exit", 32'(dbg_unlocked), 32'h0);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
